// File: rtl/iq_sample_pacer_if.sv
// Stream handshake bundle feeding the IQ sample pacer FIFO.
// The master drives data and valid; the slave returns ready.
interface iq_sample_pacer_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/iq_sample_pacer.sv
// Buffers incoming IQ sample words and replays them as a one-cycle strobe
// every clk_div+1 cycles, with underflow accounting and optional run length.
module iq_sample_pacer #(
    parameter int IQ_WIDTH        = 16,
    parameter int NUM_CH          = 1,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PRIME_LEVEL     = 4,
    parameter int DIV_WIDTH       = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             enable,
    input  logic                             start,
    input  logic                             flush,
    input  logic [DIV_WIDTH-1:0]             clk_div,
    input  logic [31:0]                      num_sample,
    iq_sample_pacer_if.slave                 s_axis,
    output logic [2*IQ_WIDTH*NUM_CH-1:0]     sample_out,
    output logic                             sample_out_strobe,
    output logic [31:0]                      sample_count,
    output logic [15:0]                      underflow_count,
    output logic                             busy,
    output logic                             done
);
    localparam int W     = 2 * IQ_WIDTH * NUM_CH;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PRIME_C = CNT_W'(PRIME_LEVEL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [W-1:0]               mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       tready_r;

    logic [1:0]           state_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic [31:0]          num_r;
    logic [DIV_WIDTH-1:0] tick_r;
    logic [W-1:0]         sample_out_r;
    logic                 strobe_r;
    logic [31:0]          sample_count_r;
    logic [15:0]          underflow_r;
    logic                 busy_r;
    logic                 done_r;

    logic             flush_ok_s;
    logic             wr_s;
    logic             rd_s;
    logic             wrap_s;
    logic             empty_s;
    logic             full_s;
    logic [CNT_W-1:0] count_nxt_s;

    // FIFO control: write/read qualification and next occupancy
    always_comb begin
        flush_ok_s  = 1'b0;
        wr_s        = 1'b0;
        rd_s        = 1'b0;
        wrap_s      = 1'b0;
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == DEPTH_C);
        count_nxt_s = count_r;

        flush_ok_s = flush && ((state_r == IDLE) || (state_r == DONE));
        wr_s       = s_axis.tvalid && tready_r && !flush_ok_s;
        wrap_s     = (state_r == RUN) && enable && (tick_r == div_r);
        rd_s       = wrap_s && !empty_s;

        if (flush_ok_s) begin
            count_nxt_s = CNT_W'(0);
        end else if (wr_s && !rd_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (rd_s && !wr_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy and ready; ready tracks !full of the new occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r   <= {FIFO_DEPTH_LOG2{1'b0}};
            rptr_r   <= {FIFO_DEPTH_LOG2{1'b0}};
            count_r  <= CNT_W'(0);
            tready_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            tready_r <= (count_nxt_s != DEPTH_C);
            if (flush_ok_s) begin
                wptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
                rptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
            end else begin
                if (wr_s) wptr_r <= wptr_r + FIFO_DEPTH_LOG2'(1);
                if (rd_s) rptr_r <= rptr_r + FIFO_DEPTH_LOG2'(1);
            end
        end
    end

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wptr_r] <= s_axis.tdata;
    end

    // Run sequencing, tick counter and registered sample outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= IDLE;
            div_r          <= {DIV_WIDTH{1'b0}};
            num_r          <= 32'd0;
            tick_r         <= {DIV_WIDTH{1'b0}};
            sample_out_r   <= {W{1'b0}};
            strobe_r       <= 1'b0;
            sample_count_r <= 32'd0;
            underflow_r    <= 16'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r        <= PRIME;
                        div_r          <= clk_div;
                        num_r          <= num_sample;
                        sample_count_r <= 32'd0;
                        underflow_r    <= 16'd0;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                    end
                end
                PRIME: begin
                    if ((count_r >= PRIME_C) || full_s) begin
                        state_r <= RUN;
                        tick_r  <= {DIV_WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    if (wrap_s) begin
                        tick_r         <= {DIV_WIDTH{1'b0}};
                        strobe_r       <= 1'b1;
                        sample_out_r   <= empty_s ? {W{1'b0}} : mem_r[rptr_r];
                        sample_count_r <= sample_count_r + 32'd1;
                        if (empty_s && (underflow_r != 16'hFFFF)) begin
                            underflow_r <= underflow_r + 16'd1;
                        end
                        if ((num_r != 32'd0) && ((sample_count_r + 32'd1) == num_r)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else if (enable) begin
                        tick_r <= tick_r + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis.tready     = tready_r;
    assign sample_out        = sample_out_r;
    assign sample_out_strobe = strobe_r;
    assign sample_count      = sample_count_r;
    assign underflow_count   = underflow_r;
    assign busy              = busy_r;
    assign done              = done_r;
endmodule

// File: tb/tb_iq_sample_pacer.sv
// Scoreboard bench for iq_sample_pacer: expected words and strobe spacing are
// queued as stimulus is driven and checked whenever the pacer strobes.
module tb_iq_sample_pacer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  clk_div = 8'd0;
    logic [31:0] num_sample = 32'd0;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic [31:0] sample_count;
    logic [15:0] underflow_count;
    logic        busy;
    logic        done;

    iq_sample_pacer_if #(.WIDTH(32)) s_axis ();

    iq_sample_pacer dut (
        .clk(clk), .rstn(rstn), .enable(enable), .start(start), .flush(flush),
        .clk_div(clk_div), .num_sample(num_sample), .s_axis(s_axis),
        .sample_out(sample_out), .sample_out_strobe(sample_out_strobe),
        .sample_count(sample_count), .underflow_count(underflow_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          gap;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned ref_cyc = 0;
    logic        prev_busy = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: pops one expectation per strobe, checks data and spacing
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rstn) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) ref_cyc = cyc;
            prev_busy = busy;
            if (sample_out_strobe) begin
                if (sb.size() == 0) begin
                    check_val("sb_extra", 64'(sample_out_strobe), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_data", 64'(sample_out), 64'(e.data));
                    check_val("sb_gap", 64'(cyc - ref_cyc), 64'(e.gap));
                end
                ref_cyc = cyc;
            end
        end
    end

    task automatic sb_push(input logic [31:0] d, input int gap);
        sb_entry_t e;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        s_axis.tdata  = d;
        s_axis.tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (s_axis.tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("push_timeout", 64'(s_axis.tready), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        s_axis.tvalid = 1'b0;
    endtask

    task automatic run_start(input logic [7:0] div, input logic [31:0] num);
        @(negedge clk);
        clk_div    = div;
        num_sample = num;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check_val("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_strobe_n(input logic [31:0] n);
        for (int k = 0; k < 200; k++) begin
            if (sample_out_strobe && sample_count == n) break;
            @(negedge clk);
        end
        check_val("strobe_n_seen", 64'(sample_count), 64'(n));
    endtask

    // Holds tvalid for a number of cycles, optionally queueing accepted words
    task automatic fill(input int cycles, input bit to_sb, input int first_gap, input int gap, output int accepted);
        accepted = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            s_axis.tdata  = 32'hA000_0000 + 32'(i);
            s_axis.tvalid = 1'b1;
            if (s_axis.tready) begin
                accepted++;
                if (to_sb) sb_push(s_axis.tdata, (accepted == 1) ? first_gap : gap);
            end
        end
    endtask

    initial begin
        int acc;
        logic [31:0] w;
        s_axis.tdata  = 32'd0;
        s_axis.tvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_tready", 64'(s_axis.tready), 64'd0);
        check_val("rst_strobe", 64'(sample_out_strobe), 64'd0);
        check_val("rst_out", 64'(sample_out), 64'd0);
        check_val("rst_count", 64'(sample_count), 64'd0);
        check_val("rst_uflow", 64'(underflow_count), 64'd0);
        check_val("rst_busy_done", {62'd0, busy, done}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rel_tready", 64'(s_axis.tready), 64'd1);

        // Basic pacing: divide by 5, eight words
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 32'h0001_0002 + 32'h0001_0001 * 32'(i);
            push_word(w);
            sb_push(w, (i == 0) ? 6 : 5);
        end
        idle_bus();
        run_start(8'd4, 32'd8);
        wait_done(200);
        repeat (3) @(negedge clk);
        check_val("t1_hold_out", 64'(sample_out), 64'h0008_0009);
        check_val("t1_count", 64'(sample_count), 64'd8);
        check_val("t1_uflow", 64'(underflow_count), 64'd0);
        check_val("t1_done", 64'(done), 64'd1);
        check_val("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Underflow: four words, seven strobes
        for (int i = 0; i < 4; i++) begin
            w = 32'h1234_0000 + 32'(i);
            push_word(w);
            sb_push(w, (i == 0) ? 4 : 3);
        end
        idle_bus();
        for (int i = 0; i < 3; i++) sb_push(32'd0, 3);
        run_start(8'd2, 32'd7);
        wait_done(200);
        @(negedge clk);
        check_val("t3_uflow", 64'(underflow_count), 64'd3);
        check_val("t3_count", 64'(sample_count), 64'd7);
        check_val("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Enable gap of 7 cycles between strobes 2 and 3
        for (int i = 0; i < 5; i++) begin
            w = 32'h5A5A_0000 + 32'(i);
            push_word(w);
            sb_push(w, (i == 0) ? 6 : ((i == 2) ? 12 : 5));
        end
        idle_bus();
        run_start(8'd4, 32'd5);
        wait_strobe_n(32'd2);
        enable = 1'b0;
        repeat (7) @(negedge clk);
        enable = 1'b1;
        wait_done(200);
        @(negedge clk);
        check_val("t4_count", 64'(sample_count), 64'd5);
        check_val("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure fill, then full-rate drain of exactly the accepted words
        fill(20, 1'b1, 2, 1, acc);
        check_val("bp_accepts", 64'(acc), 64'd16);
        check_val("bp_tready_low", 64'(s_axis.tready), 64'd0);
        idle_bus();
        run_start(8'd0, 32'd16);
        wait_done(100);
        check_val("fr_busy_fall", {62'd0, busy, sample_out_strobe}, 64'd1);
        @(negedge clk);
        check_val("fr_count", 64'(sample_count), 64'd16);
        check_val("fr_sb_empty", 64'(sb.size()), 64'd0);

        // Refill to full, then flush + start + write together
        fill(18, 1'b0, 0, 0, acc);
        check_val("bp2_tready_low", 64'(s_axis.tready), 64'd0);
        @(negedge clk);
        flush      = 1'b1;
        start      = 1'b1;
        clk_div    = 8'd0;
        num_sample = 32'd1;
        s_axis.tdata = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        s_axis.tvalid = 1'b0;
        check_val("flush_tready", 64'(s_axis.tready), 64'd1);
        repeat (10) @(negedge clk);
        check_val("flush_prime_busy", 64'(busy), 64'd1);
        check_val("flush_prime_count", 64'(sample_count), 64'd0);

        // Reset mid-run between strobes 3 and 4
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 32'hC0DE_0000 + 32'(i);
            push_word(w);
            sb_push(w, (i == 0) ? 6 : 5);
        end
        idle_bus();
        run_start(8'd4, 32'd8);
        wait_strobe_n(32'd3);
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        #1;
        check_val("mr_strobe", 64'(sample_out_strobe), 64'd0);
        check_val("mr_count", 64'(sample_count), 64'd0);
        check_val("mr_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("mr_tready", 64'(s_axis.tready), 64'd1);
        check_val("mr_idle_busy", 64'(busy), 64'd0);
        run_start(8'd0, 32'd1);
        repeat (10) @(negedge clk);
        check_val("mr_reprime_busy", 64'(busy), 64'd1);
        check_val("mr_reprime_count", 64'(sample_count), 64'd0);

        rstn = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iq_sample_pacer.md
Name: iq_sample_pacer

Overview:
Replays a buffered stream of baseband IQ samples into the receiver at a fixed, programmable sample cadence. It generalises the fixed divide-by-5 sample strobe (100 MHz clock, 20 MSPS) used to drive the dot11 receive chain. Clock ratio, IQ width, channel count and buffer depth are all parametrised. Source is an AXI-stream-style FIFO interface; sink is the sample_in/sample_in_strobe convention of dot11. Used for loopback, replay of captured samples and the regression bench.

Parameters:
IQ_WIDTH, 16, bits per I or Q component
NUM_CH, 1, number of antenna channels packed per sample word (channel 0 in the LSBs; within a channel I is upper, Q is lower)
FIFO_DEPTH_LOG2, 4, internal FIFO depth = 2**FIFO_DEPTH_LOG2 words
PRIME_LEVEL, 4, FIFO occupancy required before pacing starts (1..depth)
DIV_WIDTH, 8, width of clk_div

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  1  pacing enable; low freezes the tick counter
start  in  1  single-cycle pulse to begin a run
flush  in  1  clears the FIFO; honoured only in IDLE/DONE
clk_div  in  DIV_WIDTH  strobe period minus 1 (4 gives 100→20 MHz); sampled on start
num_sample  in  32  samples per run; 0 means unlimited
s_axis_tdata  in  2*IQ_WIDTH*NUM_CH  input sample word
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  high when the FIFO is not full
sample_out  out  2*IQ_WIDTH*NUM_CH  paced sample; holds its value between strobes
sample_out_strobe  out  1  one-cycle strobe per emitted sample
sample_count  out  32  samples emitted this run
underflow_count  out  16  strobes issued with the FIFO empty; saturates at 0xFFFF
busy  out  1  high in PRIME or RUN
done  out  1  level; high in DONE

Behaviour:
- Reset (async, rstn low):
  - All outputs go to 0, except s_axis_tready, which is 0 during reset and 1 on the first clk after release.
  - FIFO is emptied and the FSM goes to IDLE.
  - Reset mid-run aborts the run with no further strobes.
- FIFO:
  - Writes when s_axis_tvalid && s_axis_tready, in any state.
  - s_axis_tready = !full; a full FIFO never overwrites.
  - Simultaneous read and write while full is allowed. tready is still low that cycle, so no write occurs.
  - Simultaneous read and write at any other level keeps occupancy unchanged.
- FSM states: IDLE, PRIME, RUN, DONE.
  - IDLE/DONE → PRIME on start. This latches clk_div and num_sample, clears sample_count and underflow_count, and clears done.
  - start in PRIME or RUN is ignored.
  - PRIME → RUN when occupancy ≥ PRIME_LEVEL or the FIFO is full. The tick counter is set to 0 on entry.
  - RUN: tick counter increments each cycle while enable is high and wraps at the latched clk_div.
    - On the wrap cycle, the registered outputs update on the next edge: sample_out_strobe=1, sample_out = FIFO head (popped) or all-zero if the FIFO is empty.
    - An empty-FIFO strobe also increments underflow_count.
    - sample_count increments on every strobe.
  - First strobe is asserted clk_div+1 cycles after RUN entry. Strobe period = clk_div+1 cycles; clk_div=0 gives a strobe every cycle.
  - enable low: counter holds, no strobe, no pop, and the FIFO still accepts writes. A gap of g cycles stretches exactly one period by g.
  - RUN → DONE in the same cycle as the strobe that makes sample_count == num_sample (num_sample ≠ 0). done rises with that strobe. With num_sample = 0, the FSM never leaves RUN except by reset.
  - DONE holds sample_out, sample_count and underflow_count.
- flush: empties the FIFO in one cycle when in IDLE/DONE; ignored otherwise.
  - flush and a write in the same cycle: flush wins, and the FIFO is empty afterwards.
  - start and flush in the same cycle: both act; PRIME then waits for new data.
- Arithmetic:
  - sample_count wraps modulo 2^32; underflow_count saturates.
  - clk_div and num_sample changes during a run have no effect until the next start.

Test Plan:
- Basic pacing: clk_div=4, push 8 words 0x0001_0002..0x0008_0009, num_sample=8, start, enable=1 → 8 strobes exactly 5 cycles apart, data in push order, first strobe 5 cycles after RUN entry, done=1, sample_count=8, underflow_count=0.
- Full rate: clk_div=0, 16 words pre-loaded, num_sample=16 → 16 back-to-back strobes, FIFO empty after, busy falls with the last strobe.
- Underflow: PRIME_LEVEL=4, push exactly 4 words, num_sample=7, clk_div=2 → strobes 5..7 carry 0, underflow_count=3, done=1.
- Enable gap: clk_div=4, deassert enable for 7 cycles between strobes 2 and 3 → strobes 2→3 are 12 cycles apart, all other intervals 5, no sample lost or duplicated.
- Backpressure: hold tvalid=1 in IDLE with FIFO_DEPTH_LOG2=4 → tready falls after 16 accepts, the 17th word is not written, flush restores tready=1 the next cycle.
- Reset mid-run: assert rstn=0 between strobes 3 and 4 → sample_out_strobe, sample_count, busy and done are 0 immediately; after release tready=1, state IDLE, a new start requires fresh priming.
